// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and single-outstanding-fetch front end feeding decode
// Ports:
//   clk, reset                          rising-edge clock, synchronous active-high reset
//   imem_req, imem_addr                 one-cycle fetch request and its word-aligned address
//   imem_valid, imem_rdata              one-cycle memory response and its instruction word
//   redirect_valid/base/offset          taken branch: target = base + sext(offset) << 2
//   if_valid, if_ready, if_instr, if_pc instruction slot handshake towards decode
//   instr_count                         wrapping count of accepted instructions
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_valid,
    input  logic [31:0]          imem_rdata,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_base,
    input  logic [25:0]          redirect_offset,
    output logic                 if_valid,
    input  logic                 if_ready,
    output logic [31:0]          if_instr,
    output logic [31:0]          if_pc,
    output logic [CNT_WIDTH-1:0] instr_count
);
    typedef enum logic [2:0] {RST, ISSUE, WAIT, HOLD, DRAIN} state_t;
    state_t               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic                 req_q;
    logic                 valid_q, valid_d;
    logic [31:0]          instr_q, instr_d;
    logic [31:0]          ifpc_q, ifpc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]          target;
    // Low bits are masked so imem_addr stays word-aligned even for a misaligned base.
    assign target = (redirect_base + {{4{redirect_offset[25]}}, redirect_offset, 2'b00}) & 32'hFFFF_FFFC;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        cnt_d   = cnt_q;
        case (state_q)
            RST: state_d = ISSUE;
            ISSUE: begin
                // A redirect here still leaves this cycle's request in flight, so drain it.
                state_d = redirect_valid ? DRAIN : WAIT;
                pc_d    = redirect_valid ? target : pc_q;
            end
            WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_valid ? ISSUE : DRAIN;
                    pc_d    = target;
                end else if (imem_valid) begin
                    state_d = HOLD;
                    instr_d = imem_rdata;
                    ifpc_d  = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                end
            end
            HOLD: begin
                // Redirect flushes the slot even if decode accepts it in the same cycle.
                if (redirect_valid) begin
                    state_d = ISSUE;
                    valid_d = 1'b0;
                    pc_d    = target;
                end else if (if_ready) begin
                    state_d = ISSUE;
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                end
            end
            DRAIN: begin
                state_d = imem_valid ? ISSUE : DRAIN;
                pc_d    = redirect_valid ? target : pc_q;
            end
            default: state_d = RST;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RST;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            ifpc_q  <= 32'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= (state_d == ISSUE);
            valid_q <= valid_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            cnt_q   <= cnt_d;
        end
    end
    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign if_valid    = valid_q;
    assign if_instr    = instr_q;
    assign if_pc       = ifpc_q;
    assign instr_count = cnt_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: cycle-table checks of the fetch unit plus a PC/counter wrap sequence
module tb_instruction_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        reset0 = 1'b1, iv0 = 1'b0, rv0 = 1'b0, rdy0 = 1'b0;
    logic [31:0] rd0 = '0, rb0 = '0;
    logic [25:0] ro0 = '0;
    logic        req0, v0;
    logic [31:0] addr0, ins0, pc0;
    logic [15:0] cnt0;
    logic        reset1 = 1'b1, iv1 = 1'b0, rdy1 = 1'b1;
    logic [31:0] rd1 = '0;
    logic        req1, v1;
    logic [31:0] addr1, ins1, pc1;
    logic [1:0]  cnt1;
    instruction_fetch_unit #(.RESET_PC(32'h40), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .reset(reset0), .imem_req(req0), .imem_addr(addr0),
        .imem_valid(iv0), .imem_rdata(rd0), .redirect_valid(rv0),
        .redirect_base(rb0), .redirect_offset(ro0), .if_valid(v0),
        .if_ready(rdy0), .if_instr(ins0), .if_pc(pc0), .instr_count(cnt0)
    );
    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_WIDTH(2)) dut1 (
        .clk(clk), .reset(reset1), .imem_req(req1), .imem_addr(addr1),
        .imem_valid(iv1), .imem_rdata(rd1), .redirect_valid(1'b0),
        .redirect_base(32'h0), .redirect_offset(26'h0), .if_valid(v1),
        .if_ready(rdy1), .if_instr(ins1), .if_pc(pc1), .instr_count(cnt1)
    );
    typedef struct {
        logic        rst, iv;
        logic [31:0] rd;
        logic        rv;
        logic [31:0] rb;
        logic [25:0] ro;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc, ins;
        logic [15:0] cnt;
    } vec_t;
    vec_t tv[$];
    int checks = 0, failures = 0;
    task automatic add(input logic rst, input logic iv, input logic [31:0] rd, input logic rv,
                       input logic [31:0] rb, input logic [25:0] ro, input logic rdy,
                       input logic req, input logic [31:0] addr, input logic v,
                       input logic [31:0] pc, input logic [31:0] ins, input logic [15:0] cnt);
        tv.push_back('{rst, iv, rd, rv, rb, ro, rdy, req, addr, v, pc, ins, cnt});
    endtask
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    initial begin
        logic [31:0] exp_pc;
        // Boot from 0x40 and stream three instructions with decode always ready.
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 'h40, 0, 0, 0, 0);
        add(0, 0, 0,            0, 0, 0, 1, 1, 'h40, 0, 0,     0,            0);
        add(0, 0, 0,            0, 0, 0, 1, 0, 'h40, 0, 0,     0,            0);
        add(0, 1, 'h8B020020,   0, 0, 0, 1, 0, 'h44, 1, 'h40,  'h8B020020,   0);
        add(0, 0, 0,            0, 0, 0, 1, 1, 'h44, 0, 'h40,  'h8B020020,   1);
        add(0, 0, 0,            0, 0, 0, 1, 0, 'h44, 0, 'h40,  'h8B020020,   1);
        add(0, 1, 'h44,         0, 0, 0, 1, 0, 'h48, 1, 'h44,  'h44,         1);
        add(0, 0, 0,            0, 0, 0, 1, 1, 'h48, 0, 'h44,  'h44,         2);
        add(0, 0, 0,            0, 0, 0, 1, 0, 'h48, 0, 'h44,  'h44,         2);
        add(0, 1, 'h48,         0, 0, 0, 1, 0, 'h4C, 1, 'h48,  'h48,         2);
        add(0, 0, 0,            0, 0, 0, 1, 1, 'h4C, 0, 'h48,  'h48,         3);
        // Backpressure: slot at 0x4C held for five cycles, stray response ignored.
        add(0, 0, 0,            0, 0, 0, 0, 0, 'h4C, 0, 'h48,  'h48,         3);
        add(0, 1, 'h4C,         0, 0, 0, 0, 0, 'h50, 1, 'h4C,  'h4C,         3);
        add(0, 0, 0,            0, 0, 0, 0, 0, 'h50, 1, 'h4C,  'h4C,         3);
        add(0, 0, 0,            0, 0, 0, 0, 0, 'h50, 1, 'h4C,  'h4C,         3);
        add(0, 1, 'hDEADBEEF,   0, 0, 0, 0, 0, 'h50, 1, 'h4C,  'h4C,         3);
        add(0, 0, 0,            0, 0, 0, 0, 0, 'h50, 1, 'h4C,  'h4C,         3);
        add(0, 0, 0,            0, 0, 0, 0, 0, 'h50, 1, 'h4C,  'h4C,         3);
        add(0, 0, 0,            0, 0, 0, 1, 1, 'h50, 0, 'h4C,  'h4C,         4);
        add(0, 0, 0,            0, 0, 0, 0, 0, 'h50, 0, 'h4C,  'h4C,         4);
        add(0, 1, 'h50,         0, 0, 0, 0, 0, 'h54, 1, 'h50,  'h50,         4);
        // Redirect in HOLD with if_ready high: 0x48 + (-2 << 2) = 0x40, no count.
        add(0, 0, 0,            1, 'h48, 26'h3FFFFFE, 1, 1, 'h40, 0, 'h50, 'h50, 4);
        add(0, 0, 0,            0, 0, 0, 0, 0, 'h40, 0, 'h50,  'h50,         4);
        // Redirect in WAIT, 4-cycle memory: 0x100 + (3 << 2) = 0x10C after stale response.
        add(0, 0, 0,            1, 'h100, 3, 0, 0, 'h10C, 0, 'h50, 'h50,     4);
        add(0, 0, 0,            0, 0, 0, 0, 0, 'h10C, 0, 'h50, 'h50,         4);
        add(0, 0, 0,            0, 0, 0, 0, 0, 'h10C, 0, 'h50, 'h50,         4);
        add(0, 1, 'hBAD0BAD0,   0, 0, 0, 0, 1, 'h10C, 0, 'h50, 'h50,         4);
        add(0, 0, 0,            0, 0, 0, 0, 0, 'h10C, 0, 'h50, 'h50,         4);
        add(0, 1, 'h10C,        0, 0, 0, 0, 0, 'h110, 1, 'h10C, 'h10C,       4);
        add(0, 0, 0,            0, 0, 0, 1, 1, 'h110, 0, 'h10C, 'h10C,       5);
        // Redirect in ISSUE, re-redirect in DRAIN, then DRAIN valid+redirect.
        add(0, 0, 0,            1, 'h200, 0, 0, 0, 'h200, 0, 'h10C, 'h10C,   5);
        add(0, 0, 0,            1, 'h300, 1, 0, 0, 'h304, 0, 'h10C, 'h10C,   5);
        add(0, 1, 'hDEAD0001,   1, 'h400, 26'h3FFFFFF, 0, 1, 'h3FC, 0, 'h10C, 'h10C, 5);
        add(0, 0, 0,            0, 0, 0, 0, 0, 'h3FC, 0, 'h10C, 'h10C,       5);
        add(0, 1, 'h3FC,        0, 0, 0, 0, 0, 'h400, 1, 'h3FC, 'h3FC,       5);
        add(0, 0, 0,            0, 0, 0, 1, 1, 'h400, 0, 'h3FC, 'h3FC,       6);
        // WAIT with response and redirect together: response dropped, fetch target next.
        add(0, 0, 0,            0, 0, 0, 0, 0, 'h400, 0, 'h3FC, 'h3FC,       6);
        add(0, 1, 'hDEAD0002,   1, 'h80, 0, 0, 1, 'h80, 0, 'h3FC, 'h3FC,     6);
        // Mid-run reset; responses right after release are ignored.
        add(1, 0, 0,            0, 0, 0, 0, 0, 'h40, 0, 0,     0,            0);
        add(0, 1, 'hDEAD0003,   0, 0, 0, 0, 1, 'h40, 0, 0,     0,            0);
        add(0, 1, 'hDEAD0004,   0, 0, 0, 0, 0, 'h40, 0, 0,     0,            0);
        add(0, 1, 'h40,         0, 0, 0, 0, 0, 'h44, 1, 'h40,  'h40,         0);
        foreach (tv[i]) begin
            @(negedge clk);
            reset0 = tv[i].rst; iv0 = tv[i].iv; rd0 = tv[i].rd; rv0 = tv[i].rv;
            rb0 = tv[i].rb; ro0 = tv[i].ro; rdy0 = tv[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.imem_req", i), 32'(req0), 32'(tv[i].req));
            chk($sformatf("v%0d.imem_addr", i), addr0, tv[i].addr);
            chk($sformatf("v%0d.if_valid", i), 32'(v0), 32'(tv[i].v));
            chk($sformatf("v%0d.if_pc", i), pc0, tv[i].pc);
            chk($sformatf("v%0d.if_instr", i), ins0, tv[i].ins);
            chk($sformatf("v%0d.instr_count", i), 32'(cnt0), 32'(tv[i].cnt));
        end
        @(negedge clk);
        iv0 = 1'b0; rv0 = 1'b0; rdy0 = 1'b0;
        // PC wrap from 0xFFFF_FFFC and 2-bit counter wrap on the fourth accept.
        chk("wrap.reset_addr", addr1, 32'hFFFF_FFFC);
        chk("wrap.reset_cnt", 32'(cnt1), 32'h0);
        reset1 = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_pc = 32'hFFFF_FFFC + 32'(4 * k);
            chk($sformatf("wrap%0d.req", k), 32'(req1), 32'h1);
            chk($sformatf("wrap%0d.addr", k), addr1, exp_pc);
            @(negedge clk);
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d.wait_req", k), 32'(req1), 32'h0);
            @(negedge clk);
            iv1 = 1'b1;
            rd1 = 32'hA000 + 32'(k);
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d.valid", k), 32'(v1), 32'h1);
            chk($sformatf("wrap%0d.if_pc", k), pc1, exp_pc);
            chk($sformatf("wrap%0d.if_instr", k), ins1, 32'hA000 + 32'(k));
            @(negedge clk);
            iv1 = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d.count", k), 32'(cnt1), 32'((k + 1) % 4));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
